// File: rtl/threewire_slave_pkg.sv
// rtl/threewire_slave_pkg.sv - shared three-wire bus definitions: default widths, mode constants, FSM states
package threewire_slave_pkg;

  localparam int   TW_ADDR_BITS = 9;
  localparam int   TW_DATA_BITS = 16;
  localparam logic MODE_WR      = 1'b1;
  localparam logic MODE_RD      = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_TURN,
    ST_WAIT_CS
  } tw_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/threewire_slave_sync.sv
// rtl/threewire_slave_sync.sv - STAGES-deep flip-flop synchronizer with a selectable flush value
module threewire_slave_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{rst_val_i}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/threewire_slave.sv
// rtl/threewire_slave.sv - three-wire bus responder: deserializes mode/address/write data, serializes read data
module threewire_slave
  import threewire_slave_pkg::*;
#(
  parameter int ADDR_BITS   = TW_ADDR_BITS,
  parameter int DATA_BITS   = TW_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_mode_wr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_strobe,
  input  logic [DATA_BITS-1:0] in_rd_data,
  output logic                 out_busy,
  output logic                 out_abort
);

  localparam int SHIFT_W = max_int(ADDR_BITS, DATA_BITS);
  localparam int CNT_W   = $clog2(SHIFT_W + 1);

  tw_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d, shift_in;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic mode_q, mode_d, oe_q, oe_d, wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
  logic abort_q, abort_d, armed_q, armed_d, clk_dly_q;
  logic clk_s, cs_s, data_s, rise;

  threewire_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i(in_clk), .rst_i(in_rst), .rst_val_i(1'b0), .d_i(in_tw_clock), .q_o(clk_s));
  threewire_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(in_clk), .rst_i(in_rst), .rst_val_i(1'b1), .d_i(in_tw_cs), .q_o(cs_s));
  threewire_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk_i(in_clk), .rst_i(in_rst), .rst_val_i(1'b0), .d_i(io_tw_data), .q_o(data_s));

  assign rise     = clk_s & ~clk_dly_q;
  assign shift_in = {shift_q[SHIFT_W-2:0], data_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    mode_d    = mode_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    abort_d   = 1'b0;
    armed_d   = armed_q;
    if (state_q != ST_IDLE && state_q != ST_WAIT_CS && cs_s) begin
      abort_d = 1'b1;
      oe_d    = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // After reset, wait for the flushed synchronizer to show the real CS and
        // for CS to be high, so a frame already in progress is never joined midway.
        ST_IDLE: begin
          if (!armed_q) begin
            if (cnt_q != CNT_W'(SYNC_STAGES)) cnt_d = cnt_q + CNT_W'(1);
            else if (cs_s) armed_d = 1'b1;
          end else if (!cs_s) begin
            state_d = ST_MODE;
          end
        end
        ST_MODE: if (rise) begin
          mode_d  = data_s ? MODE_WR : MODE_RD;
          state_d = ST_ADDR;
        end
        ST_ADDR: if (rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
            addr_d = shift_in[ADDR_BITS-1:0];
            if (mode_q == MODE_WR) begin
              state_d = ST_WDATA;
            end else begin
              rd_stb_d = 1'b1;
              state_d  = ST_RDATA;
            end
          end
        end
        ST_WDATA: if (rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            wr_data_d = shift_in[DATA_BITS-1:0];
            wr_stb_d  = 1'b1;
            state_d   = ST_WAIT_CS;
          end
        end
        ST_RDATA: if (rise) begin
          oe_d    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = (cnt_q == '0) ? SHIFT_W'(in_rd_data) : (shift_q << 1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = ST_TURN;
        end
        ST_TURN: if (rise) begin
          oe_d    = 1'b0;
          state_d = ST_WAIT_CS;
        end
        ST_WAIT_CS: if (cs_s) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      mode_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      abort_q   <= 1'b0;
      armed_q   <= 1'b0;
      clk_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      mode_q    <= mode_d;
      oe_q      <= oe_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      abort_q   <= abort_d;
      armed_q   <= armed_d;
      clk_dly_q <= clk_s;
    end
  end

  // Release gating is combinational so an abort or reset frees the line in the same cycle.
  assign io_tw_data    = (oe_q & ~cs_s & ~in_rst) ? shift_q[DATA_BITS-1] : 1'bz;
  assign out_addr      = addr_q;
  assign out_mode_wr   = mode_q;
  assign out_wr_data   = wr_data_q;
  assign out_wr_strobe = wr_stb_q;
  assign out_rd_strobe = rd_stb_q;
  assign out_abort     = abort_q;
  assign out_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_threewire_slave.sv
// tb/tb_threewire_slave.sv - directed vector bench: bus master tasks drive the slave, results checked against the table
module tb_threewire_slave;

  localparam int AB = 9;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tw_clk = 1'b0;
  logic          tw_cs = 1'b1;
  logic          mst_oe = 1'b0;
  logic          mst_d = 1'b0;
  logic          rd_window = 1'b0;
  logic [DB-1:0] rd_data_in = '0;
  wire           tw_data;
  logic [AB-1:0] out_addr;
  logic          out_mode_wr, out_wr_strobe, out_rd_strobe, out_busy, out_abort;
  logic [DB-1:0] out_wr_data;

  assign tw_data = mst_oe ? mst_d : 1'bz;

  threewire_slave dut (
    .in_clk(clk), .in_rst(rst), .in_tw_clock(tw_clk), .in_tw_cs(tw_cs),
    .io_tw_data(tw_data), .out_addr(out_addr), .out_mode_wr(out_mode_wr),
    .out_wr_data(out_wr_data), .out_wr_strobe(out_wr_strobe),
    .out_rd_strobe(out_rd_strobe), .in_rd_data(rd_data_in),
    .out_busy(out_busy), .out_abort(out_abort));

  always #5 clk = ~clk;

  int n_wr = 0, n_rd = 0, n_ab = 0, n_bad = 0;
  logic [AB-1:0] cap_addr = '0;
  logic          cap_mode = 1'b0;
  logic [DB-1:0] cap_wdata = '0;

  always @(negedge clk) begin
    if (out_wr_strobe) begin
      n_wr++;
      cap_addr  = out_addr;
      cap_mode  = out_mode_wr;
      cap_wdata = out_wr_data;
    end
    if (out_rd_strobe) begin
      n_rd++;
      cap_addr = out_addr;
      cap_mode = out_mode_wr;
    end
    if (out_abort) n_ab++;
    if (!mst_oe && !rd_window && tw_data !== 1'bz) n_bad++;
    if (mst_oe && tw_data !== mst_d) n_bad++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    mst_d = b;
    wait_cyc(p);
    tw_clk = 1'b1;
    wait_cyc(p);
    tw_clk = 1'b0;
  endtask

  task automatic recv_bit(output logic b, input int p);
    wait_cyc(p);
    tw_clk = 1'b1;
    wait_cyc(p);
    b = tw_data;
    tw_clk = 1'b0;
  endtask

  task automatic run_frame(input logic wr, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           input int p, output logic [DB-1:0] rd, output logic busy_mid);
    logic b;
    rd = '0;
    tw_cs = 1'b0;
    mst_oe = 1'b1;
    wait_cyc(p);
    busy_mid = out_busy;
    send_bit(wr, p);
    for (int i = AB - 1; i >= 0; i--) send_bit(a[i], p);
    if (wr) begin
      for (int i = DB - 1; i >= 0; i--) send_bit(d[i], p);
      mst_oe = 1'b0;
    end else begin
      mst_oe = 1'b0;
      rd_window = 1'b1;
      for (int i = DB - 1; i >= 0; i--) begin
        recv_bit(b, p);
        rd[i] = b;
      end
      wait_cyc(p);
      tw_clk = 1'b1;
      wait_cyc(p);
      tw_clk = 1'b0;
      rd_window = 1'b0;
    end
    wait_cyc(p);
    tw_cs = 1'b1;
    wait_cyc(2 * p + 4);
  endtask

  typedef struct {
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    int            half;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DB-1:0] got;
    logic          busy_mid, b;
    int            bw, br, ba, bb;

    vecs[0] = '{1'b0, 9'h003, 16'h003D, 4};
    vecs[1] = '{1'b1, 9'h04E, 16'h0049, 4};
    vecs[2] = '{1'b0, 9'h1FF, 16'hFFFF, 4};
    vecs[3] = '{1'b1, 9'h000, 16'h0000, 4};
    vecs[4] = '{1'b0, 9'h003, 16'h003D, 50};
    vecs[5] = '{1'b1, 9'h04E, 16'h0049, 50};
    vecs[6] = '{1'b0, 9'h155, 16'hA5A5, 6};
    vecs[7] = '{1'b1, 9'h12A, 16'h5A5A, 5};

    wait_cyc(5);
    check("rst_addr",   32'(out_addr), 32'h0);
    check("rst_mode",   32'(out_mode_wr), 32'h0);
    check("rst_wdata",  32'(out_wr_data), 32'h0);
    check("rst_strobe", 32'({out_wr_strobe, out_rd_strobe, out_abort}), 32'h0);
    check("rst_busy",   32'(out_busy), 32'h0);
    check("rst_bus_z",  32'(tw_data === 1'bz), 32'h1);
    rst = 1'b0;
    wait_cyc(10);

    for (int v = 0; v < 8; v++) begin
      bw = n_wr; br = n_rd; ba = n_ab; bb = n_bad;
      rd_data_in = vecs[v].wr ? 16'hDEAD : vecs[v].data;
      run_frame(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].half, got, busy_mid);
      check($sformatf("v%0d_busy_mid", v), 32'(busy_mid), 32'h1);
      check($sformatf("v%0d_wr_strobes", v), 32'(n_wr - bw), vecs[v].wr ? 32'd1 : 32'd0);
      check($sformatf("v%0d_rd_strobes", v), 32'(n_rd - br), vecs[v].wr ? 32'd0 : 32'd1);
      check($sformatf("v%0d_aborts", v), 32'(n_ab - ba), 32'd0);
      check($sformatf("v%0d_addr", v), 32'(cap_addr), 32'(vecs[v].addr));
      check($sformatf("v%0d_mode", v), 32'(cap_mode), 32'(vecs[v].wr));
      if (vecs[v].wr) begin
        check($sformatf("v%0d_wdata", v), 32'(cap_wdata), 32'(vecs[v].data));
        check($sformatf("v%0d_wdata_held", v), 32'(out_wr_data), 32'(vecs[v].data));
      end else begin
        check($sformatf("v%0d_rdata", v), 32'(got), 32'(vecs[v].data));
      end
      check($sformatf("v%0d_bus_misdriven", v), 32'(n_bad - bb), 32'd0);
      check($sformatf("v%0d_bus_z", v), 32'(tw_data === 1'bz), 32'h1);
      check($sformatf("v%0d_busy_end", v), 32'(out_busy), 32'h0);
    end

    // Abort after mode bit plus five address bits
    bw = n_wr; br = n_rd; ba = n_ab;
    tw_cs = 1'b0;
    mst_oe = 1'b1;
    wait_cyc(4);
    send_bit(1'b1, 4);
    for (int i = AB - 1; i >= AB - 5; i--) send_bit(b, 4);
    wait_cyc(4);
    tw_cs = 1'b1;
    mst_oe = 1'b0;
    wait_cyc(12);
    check("abort_pulses", 32'(n_ab - ba), 32'd1);
    check("abort_strobes", 32'((n_wr - bw) + (n_rd - br)), 32'd0);
    check("abort_addr_kept", 32'(out_addr), 32'h12A);
    check("abort_wdata_kept", 32'(out_wr_data), 32'h5A5A);
    check("abort_busy", 32'(out_busy), 32'h0);
    bw = n_wr;
    run_frame(1'b1, 9'h0AA, 16'h1234, 4, got, busy_mid);
    check("post_abort_wr_strobes", 32'(n_wr - bw), 32'd1);
    check("post_abort_addr", 32'(cap_addr), 32'h0AA);
    check("post_abort_wdata", 32'(cap_wdata), 32'h1234);

    // Reset in the middle of the read data phase
    ba = n_ab;
    rd_data_in = 16'h8421;
    tw_cs = 1'b0;
    mst_oe = 1'b1;
    wait_cyc(4);
    send_bit(1'b0, 4);
    for (int i = AB - 1; i >= 0; i--) send_bit(1'b1, 4);
    mst_oe = 1'b0;
    rd_window = 1'b1;
    for (int i = 0; i < 4; i++) recv_bit(b, 4);
    check("pre_rst_driving", 32'(tw_data === 1'bz), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_bus_z_same_cycle", 32'(tw_data === 1'bz), 32'h1);
    wait_cyc(1);
    rd_window = 1'b0;
    check("midrst_bus_z", 32'(tw_data === 1'bz), 32'h1);
    check("midrst_outputs", 32'({out_addr, out_mode_wr, out_busy, out_rd_strobe}), 32'h0);
    rst = 1'b0;
    bw = n_wr; br = n_rd;
    wait_cyc(8);
    check("midrst_no_restart", 32'(out_busy), 32'h0);
    tw_cs = 1'b1;
    wait_cyc(12);
    check("midrst_no_abort", 32'(n_ab - ba), 32'd0);
    rd_data_in = 16'hBEEF;
    run_frame(1'b0, 9'h010, 16'h0000, 4, got, busy_mid);
    check("post_rst_rd_strobes", 32'(n_rd - br), 32'd1);
    check("post_rst_addr", 32'(cap_addr), 32'h010);
    check("post_rst_rdata", 32'(got), 32'hBEEF);
    check("post_rst_no_wr", 32'(n_wr - bw), 32'd0);
    check("final_bus_z", 32'(tw_data === 1'bz), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
